// File: rtl/regbus_arbiter.sv
// ---------------------------------------------------------------------------
// regbus_arbiter
//   Shares the single register-file access port between host accesses
//   (decoded from the external 6502 bus) and write-only accesses from the
//   SPI debug interface. Host has priority and a one-entry hold buffer;
//   debug writes queue in a FIFO and an age limit forces a debug slot so the
//   FIFO head is never starved.
//
// Ports
//   clk25            : system clock, all logic on rising edge
//   reset            : synchronous active-high reset
//   host_wr/host_rd  : single-cycle host write / read request
//   host_addr        : host register address (5 bits)
//   host_wdata       : host write data (8 bits)
//   host_rdata       : last host read result
//   host_rdata_valid : one-cycle pulse when host_rdata updates
//   host_overrun     : sticky, a host request was lost
//   dbg_wr           : single-cycle debug write request
//   dbg_addr         : debug register address (5 bits)
//   dbg_wdata        : debug write data (8 bits)
//   dbg_level        : debug FIFO occupancy
//   dbg_overflow     : sticky, a debug write was dropped (FIFO full)
//   reg_wr/reg_rd    : registered register-file write / read strobes
//   reg_addr         : registered register-file address
//   reg_wdata        : registered register-file write data
//   reg_rdata        : register-file read data, valid while reg_rd is high
// ---------------------------------------------------------------------------
module regbus_arbiter #(
    parameter int DBG_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk25,
    input  logic                       reset,
    input  logic                       host_wr,
    input  logic                       host_rd,
    input  logic [4:0]                 host_addr,
    input  logic [7:0]                 host_wdata,
    output logic [7:0]                 host_rdata,
    output logic                       host_rdata_valid,
    output logic                       host_overrun,
    input  logic                       dbg_wr,
    input  logic [4:0]                 dbg_addr,
    input  logic [7:0]                 dbg_wdata,
    output logic [$clog2(DBG_DEPTH):0] dbg_level,
    output logic                       dbg_overflow,
    output logic                       reg_wr,
    output logic                       reg_rd,
    output logic [4:0]                 reg_addr,
    output logic [7:0]                 reg_wdata,
    input  logic [7:0]                 reg_rdata
);

    localparam int PW = $clog2(DBG_DEPTH);
    localparam int LW = PW + 1;
    localparam int AW = $clog2(STARVE_LIMIT + 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DBG_DEPTH);
    localparam logic [AW-1:0] AGE_MAX    = AW'(STARVE_LIMIT);

    // Source of the slot issued on the next clock edge
    typedef enum logic [1:0] {
        SEL_IDLE = 2'd0,
        SEL_HOLD = 2'd1,
        SEL_NEW  = 2'd2,
        SEL_DBG  = 2'd3
    } sel_t;

    // Debug FIFO storage: {addr, wdata}
    logic [12:0]   r_mem [DBG_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [AW-1:0] r_age;

    // One-entry host hold buffer
    logic          r_hold_valid;
    logic          r_hold_wr;
    logic [4:0]    r_hold_addr;
    logic [7:0]    r_hold_wdata;

    // Registered outputs
    logic          r_reg_wr;
    logic          r_reg_rd;
    logic [4:0]    r_reg_addr;
    logic [7:0]    r_reg_wdata;
    logic [7:0]    r_host_rdata;
    logic          r_host_rdata_valid;
    logic          r_host_overrun;
    logic          r_dbg_overflow;

    logic          w_new_valid;
    logic          w_conflict;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic          w_force;
    logic [12:0]   w_head;
    logic          w_push;
    logic          w_dbg_drop;
    sel_t          w_sel;
    logic          w_pop;
    logic          w_hold_load;
    logic          w_hold_clear;
    logic          w_host_drop;

    // A simultaneous write+read is treated as a write; the read is lost
    assign w_new_valid  = host_wr | host_rd;
    assign w_conflict   = host_wr & host_rd;
    assign w_fifo_empty = (r_level == {LW{1'b0}});
    assign w_fifo_full  = (r_level == FULL_LEVEL);
    assign w_force      = ~w_fifo_empty & (r_age == AGE_MAX);
    assign w_head       = r_mem[r_rd_ptr];
    // When full, a push only fits if the head leaves in the same cycle
    assign w_push       = dbg_wr & (~w_fifo_full | w_pop);
    assign w_dbg_drop   = dbg_wr & w_fifo_full & ~w_pop;

    // Slot arbitration: forced debug, then host (hold first), then debug
    always_comb begin
        w_sel        = SEL_IDLE;
        w_pop        = 1'b0;
        w_hold_load  = 1'b0;
        w_hold_clear = 1'b0;
        w_host_drop  = 1'b0;
        if (w_force) begin
            w_sel = SEL_DBG;
            w_pop = 1'b1;
            if (w_new_valid) begin
                // Hold is not drained in a forced slot, so a full hold loses the arrival
                if (r_hold_valid) begin
                    w_host_drop = 1'b1;
                end else begin
                    w_hold_load = 1'b1;
                end
            end else begin
                w_hold_load = 1'b0;
            end
        end else if (r_hold_valid) begin
            w_sel = SEL_HOLD;
            // A new arrival takes the place of the entry being drained
            if (w_new_valid) begin
                w_hold_load = 1'b1;
            end else begin
                w_hold_clear = 1'b1;
            end
        end else if (w_new_valid) begin
            w_sel = SEL_NEW;
        end else if (!w_fifo_empty) begin
            w_sel = SEL_DBG;
            w_pop = 1'b1;
        end else begin
            w_sel = SEL_IDLE;
        end
    end

    // FIFO storage write; contents are discarded on reset via the pointers
    always_ff @(posedge clk25) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= {dbg_addr, dbg_wdata};
        end
    end

    // FIFO pointers, occupancy and head age
    always_ff @(posedge clk25) begin
        if (reset) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_level  <= {LW{1'b0}};
            r_age    <= {AW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_pop || w_fifo_empty) begin
                r_age <= {AW{1'b0}};
            end else if (r_age != AGE_MAX) begin
                r_age <= r_age + AW'(1);
            end
        end
    end

    // Host hold buffer
    always_ff @(posedge clk25) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold_wr    <= 1'b0;
            r_hold_addr  <= 5'd0;
            r_hold_wdata <= 8'd0;
        end else if (w_hold_load) begin
            r_hold_valid <= 1'b1;
            r_hold_wr    <= host_wr;
            r_hold_addr  <= host_addr;
            r_hold_wdata <= host_wdata;
        end else if (w_hold_clear) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Issue the selected slot; address/data hold their value in idle cycles
    always_ff @(posedge clk25) begin
        if (reset) begin
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_reg_addr  <= 5'd0;
            r_reg_wdata <= 8'd0;
        end else begin
            case (w_sel)
                SEL_DBG: begin
                    r_reg_wr    <= 1'b1;
                    r_reg_rd    <= 1'b0;
                    r_reg_addr  <= w_head[12:8];
                    r_reg_wdata <= w_head[7:0];
                end
                SEL_HOLD: begin
                    r_reg_wr   <= r_hold_wr;
                    r_reg_rd   <= ~r_hold_wr;
                    r_reg_addr <= r_hold_addr;
                    if (r_hold_wr) begin
                        r_reg_wdata <= r_hold_wdata;
                    end
                end
                SEL_NEW: begin
                    r_reg_wr   <= host_wr;
                    r_reg_rd   <= ~host_wr;
                    r_reg_addr <= host_addr;
                    if (host_wr) begin
                        r_reg_wdata <= host_wdata;
                    end
                end
                default: begin
                    r_reg_wr <= 1'b0;
                    r_reg_rd <= 1'b0;
                end
            endcase
        end
    end

    // Read return capture and sticky error flags
    always_ff @(posedge clk25) begin
        if (reset) begin
            r_host_rdata       <= 8'd0;
            r_host_rdata_valid <= 1'b0;
            r_host_overrun     <= 1'b0;
            r_dbg_overflow     <= 1'b0;
        end else begin
            r_host_rdata_valid <= r_reg_rd;
            if (r_reg_rd) begin
                r_host_rdata <= reg_rdata;
            end
            if (w_conflict || w_host_drop) begin
                r_host_overrun <= 1'b1;
            end
            if (w_dbg_drop) begin
                r_dbg_overflow <= 1'b1;
            end
        end
    end

    assign reg_wr           = r_reg_wr;
    assign reg_rd           = r_reg_rd;
    assign reg_addr         = r_reg_addr;
    assign reg_wdata        = r_reg_wdata;
    assign host_rdata       = r_host_rdata;
    assign host_rdata_valid = r_host_rdata_valid;
    assign host_overrun     = r_host_overrun;
    assign dbg_overflow     = r_dbg_overflow;
    assign dbg_level        = r_level;

endmodule
